// File: rtl/tdc_avg_display_latch_if.sv
// Bus between the TDC encoder / display driver side and the averaging display latch.
// Valid/ready: meas_valid is a one-cycle strobe with no back-pressure; avg_valid is a one-cycle pulse.
interface tdc_avg_display_latch_if #(
  parameter int DATA_W = 12
);
  logic              meas_valid;
  logic [DATA_W-1:0] meas_data;
  logic              hold;
  logic [11:0]       byte_data_send;
  logic              avg_valid;
  logic [11:0]       avg_data;
  logic              ovf;
  logic [1:0]        fsm_state;

  modport master (
    output meas_valid, meas_data, hold,
    input  byte_data_send, avg_valid, avg_data, ovf, fsm_state
  );

  modport slave (
    input  meas_valid, meas_data, hold,
    output byte_data_send, avg_valid, avg_data, ovf, fsm_state
  );
endinterface

// File: rtl/tdc_avg_display_latch.sv
// Averages windows of TDC codes and republishes the latest average to the hex display
// at a slow refresh rate; windows containing an all-ones (overflow) code display as FFF.
module tdc_avg_display_latch #(
  parameter int DATA_W     = 12,
  parameter int AVG_LOG2   = 4,
  parameter int UPDATE_DIV = 50000000
) (
  input  logic                    CLK,
  input  logic                    RST,
  tdc_avg_display_latch_if.slave  bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int TMR_W = $clog2(UPDATE_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    WAIT_AVG  = 2'd1,
    PUBLISH   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                win_ovf_q, win_ovf_d;
  logic                win_ovf_lat_q, win_ovf_lat_d;
  logic [11:0]         avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [11:0]         disp_q, disp_d;
  logic                ovf_q, ovf_d;

  logic [ACC_W-1:0]    sum_full;
  logic [ACC_W-1:0]    sum_shift;
  logic                is_ovf_code;
  logic                win_close;
  logic                tick;

  assign sum_full    = acc_q + ACC_W'(bus.meas_data);
  assign sum_shift   = sum_full >> AVG_LOG2;
  assign is_ovf_code = &bus.meas_data;
  assign win_close   = bus.meas_valid && (cnt_q == '1);
  assign tick        = (timer_q == TMR_LAST);

  always_comb begin
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    win_ovf_d     = win_ovf_q;
    win_ovf_lat_d = win_ovf_lat_q;
    avg_d         = avg_q;
    avg_valid_d   = 1'b0;
    if (win_close) begin
      // Closing sample folds into the average and the window restarts on the same edge.
      acc_d         = '0;
      cnt_d         = '0;
      win_ovf_d     = 1'b0;
      avg_d         = 12'(sum_shift[DATA_W-1:0]);
      win_ovf_lat_d = win_ovf_q | is_ovf_code;
      avg_valid_d   = 1'b1;
    end else if (bus.meas_valid) begin
      acc_d     = sum_full;
      cnt_d     = cnt_q + 1'b1;
      win_ovf_d = win_ovf_q | is_ovf_code;
    end
  end

  always_comb begin
    timer_d   = tick ? '0 : timer_q + 1'b1;
    pending_d = pending_q | tick;
    state_d   = state_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    case (state_q)
      WAIT_TICK: if (pending_q) state_d = WAIT_AVG;
      WAIT_AVG:  if (avg_valid_q) state_d = PUBLISH;
      PUBLISH: begin
        if (bus.hold) begin
          state_d = WAIT_AVG;
        end else begin
          // Clearing wins over a coincident tick: ticks during pending are absorbed.
          disp_d    = win_ovf_lat_q ? 12'hFFF : avg_q;
          ovf_d     = win_ovf_lat_q;
          pending_d = 1'b0;
          state_d   = WAIT_TICK;
        end
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= WAIT_TICK;
      acc_q         <= '0;
      cnt_q         <= '0;
      win_ovf_q     <= 1'b0;
      win_ovf_lat_q <= 1'b0;
      avg_q         <= '0;
      avg_valid_q   <= 1'b0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      disp_q        <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      win_ovf_q     <= win_ovf_d;
      win_ovf_lat_q <= win_ovf_lat_d;
      avg_q         <= avg_d;
      avg_valid_q   <= avg_valid_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      disp_q        <= disp_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.byte_data_send = disp_q;
  assign bus.avg_valid      = avg_valid_q;
  assign bus.avg_data       = avg_q;
  assign bus.ovf            = ovf_q;
  assign bus.fsm_state      = state_q;
endmodule

// File: tb/tb_tdc_avg_display_latch.sv
// Bench for tdc_avg_display_latch with 4-sample windows and an 8-cycle refresh tick.
module tb_tdc_avg_display_latch;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  logic [11:0] exp_q[$];
  int   pulse_q[$];

  tdc_avg_display_latch_if #(.DATA_W(12)) bus ();

  tdc_avg_display_latch #(
    .DATA_W(12),
    .AVG_LOG2(2),
    .UPDATE_DIV(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every avg_valid pulse must match the oldest expected average
  always @(negedge clk) begin
    if (!rst && bus.avg_valid === 1'b1) begin
      checks++;
      pulse_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL avg_unexpected: got avg_data=%h with no expected average", bus.avg_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (bus.avg_data !== e) begin
          failures++;
          $display("FAIL avg_data: got %h expected %h", bus.avg_data, e);
        end
      end
    end
  end

  // Driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] d);
    bus.meas_valid = 1'b1;
    bus.meas_data  = d;
    @(posedge clk);
    #1;
    bus.meas_valid = 1'b0;
  endtask

  // Sends one window with a long gap before the closing sample so a tick is pending;
  // returns just after the closing edge.
  task automatic run_window(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d);
    logic [13:0] sum;
    sum = 14'(a) + 14'(b) + 14'(c) + 14'(d);
    send(a); idle(1);
    send(b); idle(1);
    send(c); idle(10);
    exp_q.push_back(12'(sum >> 2));
    send(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.meas_valid = 1'b0;
    bus.meas_data  = '0;
    bus.hold       = 1'b0;
    idle(3);
    checks++;
    if (bus.byte_data_send !== 12'h000 || bus.avg_data !== 12'h000 ||
        bus.avg_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got disp=%h avg=%h av=%b ovf=%b st=%0d expected all zero",
               bus.byte_data_send, bus.avg_data, bus.avg_valid, bus.ovf, bus.fsm_state);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    run_window(12'd10, 12'd20, 12'd30, 12'd40);
    idle(1);
    checks++;
    if (bus.byte_data_send !== 12'h000) begin
      failures++;
      $display("FAIL basic_latency: got %h expected %h one cycle after close", bus.byte_data_send, 12'h000);
    end
    idle(1);
    checks++;
    if (bus.byte_data_send !== 12'h019 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_display: got %h ovf=%b expected 019 ovf=0", bus.byte_data_send, bus.ovf);
    end
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run_window(12'h055, 12'h055, 12'h055, 12'h055);
      idle(3);
      checks++;
      if (bus.byte_data_send !== 12'h019) begin
        failures++;
        $display("FAIL hold_frozen: window %0d got %h expected 019", w, bus.byte_data_send);
      end
    end
    bus.hold = 1'b0;
    run_window(12'h055, 12'h055, 12'h055, 12'h055);
    idle(2);
    checks++;
    if (bus.byte_data_send !== 12'h055) begin
      failures++;
      $display("FAIL hold_release: got %h expected 055", bus.byte_data_send);
    end
  endtask

  task automatic test_truncation();
    run_window(12'd1, 12'd1, 12'd1, 12'd2);
    idle(2);
    checks++;
    if (bus.byte_data_send !== 12'h001 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL truncation_display: got %h ovf=%b expected 001 ovf=0", bus.byte_data_send, bus.ovf);
    end
  endtask

  task automatic test_overflow();
    run_window(12'h100, 12'hFFF, 12'h100, 12'h100);
    idle(2);
    checks++;
    if (bus.byte_data_send !== 12'hFFF || bus.ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_display: got %h ovf=%b expected FFF ovf=1", bus.byte_data_send, bus.ovf);
    end
    run_window(12'h123, 12'h123, 12'h123, 12'h123);
    idle(2);
    checks++;
    if (bus.byte_data_send !== 12'h123 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: got %h ovf=%b expected 123 ovf=0", bus.byte_data_send, bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] sum;
    pulse_q.delete();
    for (int w = 0; w < 3; w++) begin
      sum = '0;
      for (int k = 0; k < 4; k++) begin
        logic [11:0] d;
        d = 12'($urandom_range(0, 4094));
        sum = sum + 14'(d);
        if (k == 3) exp_q.push_back(12'(sum >> 2));
        send(d);
        bus.meas_valid = (k != 3 || w != 2);
      end
    end
    bus.meas_valid = 1'b0;
    idle(3);
    checks++;
    if (pulse_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d avg_valid pulses expected 3", pulse_q.size());
    end else begin
      checks++;
      if (pulse_q[1] - pulse_q[0] != 4 || pulse_q[2] - pulse_q[1] != 4) begin
        failures++;
        $display("FAIL b2b_spacing: got gaps %0d,%0d expected 4,4",
                 pulse_q[1] - pulse_q[0], pulse_q[2] - pulse_q[1]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drained: got %0d averages outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_window();
    idle(10);
    send(12'h300); idle(1);
    send(12'h300);
    rst = 1'b1;
    idle(1);
    checks++;
    if (bus.byte_data_send !== 12'h000 || bus.avg_data !== 12'h000 ||
        bus.avg_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got disp=%h avg=%h av=%b ovf=%b expected all zero",
               bus.byte_data_send, bus.avg_data, bus.avg_valid, bus.ovf);
    end
    idle(1);
    rst = 1'b0;
    idle(1);
    run_window(12'h00A, 12'h00A, 12'h00A, 12'h00A);
    idle(2);
    checks++;
    if (bus.byte_data_send !== 12'h00A || bus.avg_data !== 12'h00A) begin
      failures++;
      $display("FAIL reset_mid_fresh: got disp=%h avg=%h expected 00A", bus.byte_data_send, bus.avg_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_truncation();
    test_overflow();
    test_back_to_back();
    test_reset_mid_window();
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: got %0d averages never produced expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
